fp_exe_trace: RTL and testbench

- Synthesizable transaction recorder on the fp_exe request/response interface of fp_unit; the writer side of the vector-file format the float test benches read.
- Captures the operands and op fields when a request is issued.
- When ready arrives, pairs them with result and flags and packs one 288-bit record in the bench vector layout.
- Buffers records in a FIFO and streams each one out as nine 32-bit words, for on-chip capture or FPGA vector regeneration.

---
 rtl/fp_wire_pkg.sv | 71 +++++++
 rtl/fp_exe_trace_fifo.sv | 44 ++++
 rtl/fp_exe_trace.sv | 126 ++++++++++++
 tb/tb_fp_exe_trace.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_wire_pkg.sv
// fp_wire: fp_unit execute-bus types plus the trace record layout used by fp_exe_trace.
package fp_wire;

  localparam int FP_TRACE_REC_W = 288;
  localparam int FP_TRACE_WORDS = 9;

  typedef struct packed {
    logic       fmadd;
    logic       fadd;
    logic       fsub;
    logic       fmul;
    logic       fdiv;
    logic       fsqrt;
    logic       fcmp;
    logic       fcvt_f2f;
    logic       fcvt_i2f;
    logic       fcvt_f2i;
    logic [1:0] fcvt_op;
  } fp_operation_type;

  typedef struct packed {
    logic [63:0]      data1;
    logic [63:0]      data2;
    logic [63:0]      data3;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    fp_operation_type op;
    logic             enable;
  } fp_exe_in_type;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
    logic        ready;
  } fp_exe_out_type;

  typedef struct packed {
    logic [63:0] data1;
    logic [63:0] data2;
    logic [63:0] data3;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [1:0]  fcvt_op;
    logic [9:0]  opcode;
  } fp_trace_req_type;

  typedef struct packed {
    logic [63:0] data1;
    logic [63:0] data2;
    logic [63:0] data3;
    logic [63:0] result;
    logic [2:0]  pad_31_29;
    logic [4:0]  flags;
    logic [1:0]  pad_23_22;
    logic [1:0]  fmt;
    logic        pad_19;
    logic [2:0]  rm;
    logic [1:0]  pad_15_14;
    logic [1:0]  fcvt_op;
    logic [1:0]  pad_11_10;
    logic [9:0]  opcode;
  } fp_trace_rec_type;

  typedef enum logic {TR_IDLE, TR_SEND} fp_trace_state_type;

  function automatic logic [9:0] fp_trace_opcode(input fp_operation_type op);
    return {op.fcvt_f2i, op.fcvt_i2f, op.fcvt_f2f, op.fcmp, op.fsqrt,
            op.fdiv, op.fmul, op.fsub, op.fadd, op.fmadd};
  endfunction

endpackage

// File: rtl/fp_exe_trace_fifo.sv
// fp_trace_fifo: synchronous FIFO; pointers carry an extra MSB to tell full from empty.
module fp_trace_fifo #(
  parameter int W     = 288,
  parameter int DEPTH = 4
) (
  input  logic         reset,
  input  logic         clock,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         wr_en, rd_en;

  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  always_comb begin
    empty = wr_q == rd_q;
    full  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    rd_en = pop && !empty;
    wr_en = push && (!full || rd_en);
    wr_d  = wr_q + (AW+1)'(wr_en);
    rd_d  = rd_q + (AW+1)'(rd_en);
    dout  = mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
    if (wr_en && reset) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fp_exe_trace.sv
// fp_exe_trace: records fp_exe request/response pairs and streams each record as 32-bit words.
// FP_TRACE_TIMESTAMP_EN appends a 32-bit capture-cycle timestamp as an extra final word.
module fp_exe_trace
  import fp_wire::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             reset,
  input  logic             clock,
  input  fp_exe_in_type    fp_exe_i,
  input  fp_exe_out_type   fp_exe_o,
  output logic [31:0]      m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             proto_err
);

`ifdef FP_TRACE_TIMESTAMP_EN
  localparam int REC_W = FP_TRACE_REC_W + 32;
  localparam int WORDS = FP_TRACE_WORDS + 1;
`else
  localparam int REC_W = FP_TRACE_REC_W;
  localparam int WORDS = FP_TRACE_WORDS;
`endif

  fp_trace_req_type   req_q, req_d;
  fp_trace_rec_type   rec;
  fp_trace_state_type state_q, state_d;
  logic               pending_q, pending_d, proto_err_q, proto_err_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic [REC_W-1:0]   sr_q, sr_d, rec_w, head;
  logic               push, pop, full, empty, hs, last;

  always_comb begin
    push = fp_exe_o.ready && pending_q;
    rec = '0;
    rec.data1 = req_q.data1;
    rec.data2 = req_q.data2;
    rec.data3 = req_q.data3;
    rec.result = fp_exe_o.result;
    rec.flags = fp_exe_o.flags;
    rec.fmt = req_q.fmt;
    rec.rm = req_q.rm;
    rec.fcvt_op = req_q.fcvt_op;
    rec.opcode = req_q.opcode;
    req_d = fp_exe_i.enable ? '{data1: fp_exe_i.data1, data2: fp_exe_i.data2, data3: fp_exe_i.data3,
                                fmt: fp_exe_i.fmt, rm: fp_exe_i.rm, fcvt_op: fp_exe_i.op.fcvt_op,
                                opcode: fp_trace_opcode(fp_exe_i.op)} : req_q;
    // completion uses the old request before any same-cycle capture replaces it
    pending_d = fp_exe_i.enable || (pending_q && !fp_exe_o.ready);
    proto_err_d = proto_err_q || (fp_exe_o.ready && !pending_q) ||
                  (fp_exe_i.enable && pending_q && !fp_exe_o.ready);
    drop_cnt_d = (push && full && !pop && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
  end

`ifdef FP_TRACE_TIMESTAMP_EN
  logic [31:0] ts_q, ts_cap_q;
  always_ff @(posedge clock) begin
    if (!reset) begin
      ts_q <= '0;
      ts_cap_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
      ts_cap_q <= fp_exe_i.enable ? ts_q : ts_cap_q;
    end
  end
  assign rec_w = {rec, ts_cap_q};
`else
  assign rec_w = rec;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      req_q <= '0;
      pending_q <= 1'b0;
      proto_err_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      req_q <= req_d;
      pending_q <= pending_d;
      proto_err_q <= proto_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fp_trace_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .reset(reset), .clock(clock), .push(push), .din(rec_w),
    .pop(pop), .dout(head), .full(full), .empty(empty)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= TR_IDLE;
      idx_q <= '0;
      sr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      sr_q <= sr_d;
    end
  end

  // reloading on the last handshake keeps back-to-back records bubble-free
  always_comb begin
    hs = m_valid && m_ready;
    last = idx_q == 4'(WORDS - 1);
    pop = !empty && (state_q == TR_IDLE || (hs && last));
    state_d = pop ? TR_SEND : (hs && last) ? TR_IDLE : state_q;
    idx_d = pop ? '0 : hs ? idx_q + 4'd1 : idx_q;
    sr_d = pop ? head : hs ? sr_q << 32 : sr_q;
  end

  always_comb begin
    m_valid = state_q == TR_SEND;
    m_data = sr_q[REC_W-1 -: 32];
    m_last = m_valid && idx_q == 4'(WORDS - 1);
  end

  assign drop_cnt = drop_cnt_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_fp_exe_trace.sv
// tb_fp_exe_trace: directed and random stimulus against a queue-level model of the trace recorder.
module tb_fp_exe_trace;
  import fp_wire::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
`ifdef FP_TRACE_TIMESTAMP_EN
  localparam int NW = 10;
`else
  localparam int NW = 9;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  fp_exe_in_type fi;
  fp_exe_out_type fo;
  logic [31:0] m_data;
  logic m_valid, m_last, m_ready;
  logic [CNT_W-1:0] drop_cnt;
  logic proto_err;

  always #5 clock = ~clock;

  fp_exe_trace #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .reset(reset), .clock(clock), .fp_exe_i(fi), .fp_exe_o(fo),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .drop_cnt(drop_cnt), .proto_err(proto_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [319:0] mk_rec(input logic [63:0] d1, input logic [63:0] d2,
      input logic [63:0] d3, input logic [63:0] res, input logic [4:0] fl, input logic [1:0] fmt,
      input logic [2:0] rm, input logic [1:0] fc, input logic [9:0] opc, input logic [31:0] ts);
    logic [31:0] w [10];
    logic [319:0] r;
    w[0] = d1[63:32]; w[1] = d1[31:0];
    w[2] = d2[63:32]; w[3] = d2[31:0];
    w[4] = d3[63:32]; w[5] = d3[31:0];
    w[6] = res[63:32]; w[7] = res[31:0];
    w[8] = 32'(fl) * 32'h0100_0000 + 32'(fmt) * 32'h0010_0000 + 32'(rm) * 32'h0001_0000 +
           32'(fc) * 32'h0000_1000 + 32'(opc);
    w[9] = ts;
    r = '0;
    for (int i = 0; i < NW; i++) r[319-32*i -: 32] = w[i];
    return r;
  endfunction

  // reference model: request register, record queue and the word stream in flight
  logic [319:0] mfifo [$];
  logic [319:0] cur_rec;
  int cur_left, drops, tcount, pre;
  bit pend, perr, popd;
  logic [63:0] r_d1, r_d2, r_d3;
  logic [1:0] r_fmt, r_fc;
  logic [2:0] r_rm;
  logic [9:0] r_opc;
  logic [31:0] r_ts;

  always @(posedge clock) begin
    if (!reset) begin
      mfifo.delete();
      cur_left = 0; drops = 0; tcount = 0; pend = 0; perr = 0; cur_rec = '0;
    end else begin
      pre = mfifo.size();
      popd = 0;
      if (cur_left > 0 && m_ready) begin
        cur_rec = cur_rec << 32;
        cur_left--;
      end
      if (cur_left == 0 && pre > 0) begin
        cur_rec = mfifo.pop_front();
        cur_left = NW;
        popd = 1;
      end
      if (fo.ready && pend) begin
        if (pre < DEPTH || popd)
          mfifo.push_back(mk_rec(r_d1, r_d2, r_d3, fo.result, fo.flags, r_fmt, r_rm, r_fc, r_opc, r_ts));
        else if (drops < (1 << CNT_W) - 1)
          drops++;
      end
      if ((fo.ready && !pend) || (fi.enable && pend && !fo.ready)) perr = 1;
      if (fi.enable) begin
        r_d1 = fi.data1; r_d2 = fi.data2; r_d3 = fi.data3;
        r_fmt = fi.fmt; r_rm = fi.rm; r_fc = fi.op.fcvt_op;
        r_opc = {fi.op.fcvt_f2i, fi.op.fcvt_i2f, fi.op.fcvt_f2f, fi.op.fcmp, fi.op.fsqrt,
                 fi.op.fdiv, fi.op.fmul, fi.op.fsub, fi.op.fadd, fi.op.fmadd};
        r_ts = tcount;
        pend = 1;
      end else if (fo.ready) pend = 0;
      tcount++;
    end
  end

  bit chk_on = 0;
  logic [31:0] got [$];
  bit got_last [$];

  always @(negedge clock) begin
    if (chk_on) begin
      check("m_valid", m_valid, cur_left > 0);
      if (cur_left > 0) begin
        check("m_data", m_data, cur_rec[319 -: 32]);
        check("m_last", m_last, cur_left == 1);
      end
      check("drop_cnt", drop_cnt, drops);
      check("proto_err", proto_err, perr);
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        got_last.push_back(m_last);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] d3,
      input logic [1:0] fmt, input logic [2:0] rm, input logic [1:0] fc, input logic [9:0] opc);
    fi.data1 = d1; fi.data2 = d2; fi.data3 = d3;
    fi.fmt = fmt; fi.rm = rm; fi.op.fcvt_op = fc;
    {fi.op.fcvt_f2i, fi.op.fcvt_i2f, fi.op.fcvt_f2f, fi.op.fcmp, fi.op.fsqrt,
     fi.op.fdiv, fi.op.fmul, fi.op.fsub, fi.op.fadd, fi.op.fmadd} = opc;
    fi.enable = 1'b1;
  endtask

  task automatic resp(input logic [63:0] r, input logic [4:0] fl);
    fo.result = r; fo.flags = fl; fo.ready = 1'b1;
  endtask

  task automatic quiet();
    fi.enable = 1'b0;
    fo.ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_words(input int n, input int budget);
    int c = 0;
    while (got.size() < n && c < budget) begin
      tick();
      c++;
    end
    check("word_count", got.size(), n);
  endtask

  localparam logic [31:0] FADD_W [9] = '{32'h0, 32'h3F80_0000, 32'h0, 32'h4000_0000, 32'h0, 32'h0,
                                         32'h0, 32'h4040_0000, 32'h0000_0002};

  initial begin
    logic [319:0] exp_rec;
    logic [3:0] pat;
    int c;
    fi = '0;
    fo = '0;
    m_ready = 1'b0;
    @(posedge clock);
    #1;
    chk_on = 1;
    repeat (2) tick();
    reset = 1'b1;
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);

    // single fadd, ready three cycles after the request
    m_ready = 1'b1;
    got.delete(); got_last.delete();
    req(64'h3F80_0000, 64'h4000_0000, 64'h0, 2'd0, 3'd0, 2'd0, 10'h002);
    tick();
    quiet();
    repeat (2) tick();
    resp(64'h4040_0000, 5'd0);
    tick();
    quiet();
    wait_words(NW, 40);
    for (int i = 0; i < 9; i++) check($sformatf("fadd_w%0d", i), got[i], FADD_W[i]);
    check("fadd_last8", got_last[NW-1], 1);
    check("fadd_last7", got_last[NW-2], 0);

    // stalled stream with m_ready pattern 1,0,0,1
    got.delete(); got_last.delete();
    req(64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_1111_2222, 64'h3333_4444_5555_6666, 2'd1, 3'd3, 2'd2, 10'h080);
    tick();
    quiet();
    tick();
    resp(64'hCAFE_F00D_7777_8888, 5'h15);
    tick();
    quiet();
    exp_rec = mk_rec(64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_1111_2222, 64'h3333_4444_5555_6666,
                     64'hCAFE_F00D_7777_8888, 5'h15, 2'd1, 3'd3, 2'd2, 10'h080, 32'd0);
    pat = 4'b1001;
    for (int k = 0; k < 24; k++) begin
      m_ready = pat[k % 4];
      tick();
    end
    m_ready = 1'b1;
    wait_words(NW, 40);
    for (int i = 0; i < 9; i++) check($sformatf("stall_w%0d", i), got[i], exp_rec[319-32*i -: 32]);

    // reset in the middle of a record
    for (int k = 0; k < 2; k++) begin
      req(64'(k + 7), 64'h1, 64'h2, 2'd0, 3'd1, 2'd0, 10'h008);
      tick();
      quiet();
      resp(64'h55, 5'd1);
      tick();
      quiet();
    end
    c = 0;
    while (!m_valid && c < 20) begin
      tick();
      c++;
    end
    check("midsend_valid", m_valid, 1);
    repeat (4) tick();
    do_reset();
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_perr", proto_err, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("mid_rst_empty", m_valid, 0);
    end

    // overflow with the stream stalled
    m_ready = 1'b0;
    got.delete(); got_last.delete();
    for (int k = 0; k < DEPTH + 4; k++) begin
      req(64'(k), 64'h0, 64'h0, 2'd0, 3'd0, 2'd0, 10'h004);
      tick();
      quiet();
      resp(64'(k + 100), 5'd0);
      tick();
      quiet();
    end
    tick();
    check("drop3", drop_cnt, 3);
    for (int k = 0; k < 5; k++) begin
      req(64'(k + 50), 64'h0, 64'h0, 2'd0, 3'd0, 2'd0, 10'h004);
      tick();
      quiet();
      resp(64'h0, 5'd0);
      tick();
      quiet();
    end
    check("drop_sat", drop_cnt, 7);
    m_ready = 1'b1;
    wait_words((DEPTH + 1) * NW, 200);
    for (int j = 0; j <= DEPTH; j++) check($sformatf("order%0d", j), got[j*NW+1], j);
    repeat (20) tick();
    check("no_extra", got.size(), (DEPTH + 1) * NW);

    // protocol violations
    do_reset();
    req(64'h1, 64'h2, 64'h3, 2'd0, 3'd0, 2'd0, 10'h001);
    tick();
    req(64'h4, 64'h5, 64'h6, 2'd0, 3'd0, 2'd0, 10'h001);
    tick();
    quiet();
    tick();
    check("perr_double_en", proto_err, 1);
    do_reset();
    check("perr_cleared", proto_err, 0);
    resp(64'h9, 5'd0);
    tick();
    quiet();
    check("perr_orphan", proto_err, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("orphan_nopush", m_valid, 0);
    end

    // back-to-back fdiv then fsqrt with overlapping ready/enable
    do_reset();
    got.delete(); got_last.delete();
    req(64'hA, 64'hB, 64'h0, 2'd0, 3'd0, 2'd0, 10'h010);
    tick();
    req(64'hC, 64'h0, 64'h0, 2'd0, 3'd0, 2'd0, 10'h020);
    resp(64'h1111, 5'd0);
    tick();
    quiet();
    tick();
    resp(64'h2222, 5'd0);
    tick();
    quiet();
    wait_words(2 * NW, 60);
    check("fdiv_op", got[8], 32'h010);
    check("fdiv_res", got[7], 32'h1111);
    check("fsqrt_op", got[NW+8], 32'h020);
    check("fsqrt_res", got[NW+7], 32'h2222);
    check("fsqrt_d1", got[NW+1], 32'hC);
    check("overlap_perr", proto_err, 0);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      fi.enable = ($urandom % 3) == 0;
      fi.data1 = {$urandom, $urandom};
      fi.data2 = {$urandom, $urandom};
      fi.data3 = {$urandom, $urandom};
      fi.fmt = 2'($urandom);
      fi.rm = 3'($urandom);
      fi.op = fp_operation_type'(12'($urandom));
      fo.ready = ($urandom % 3) == 0;
      fo.result = {$urandom, $urandom};
      fo.flags = 5'($urandom);
      m_ready = ($urandom % 4) != 0;
      tick();
    end
    quiet();
    m_ready = 1'b1;
    repeat (80) tick();
    check("drain_idle", m_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
